// File: rtl/alu_issue_queue.sv
// alu_issue_queue: request FIFO plus issue FSM in front of the 8-bit ALU.
// Keeps the carry/borrow chain between operations and returns results over valid/ready.
// Optional watchdog: define ALU_ISSUE_TIMEOUT_EN to abort an operation whose result never arrives.
module alu_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [4:0] instr_opcode,
    input  logic [7:0] instr_a,
    input  logic [7:0] instr_b,
    output logic [4:0] opcode,
    output logic [7:0] operand_A,
    output logic [7:0] operand_B,
    output logic       enable,
    output logic       input_ready,
    output logic       carry_in,
    output logic       borrow_in,
    input  logic       result_ready,
    input  logic [7:0] y_out,
    input  logic       carry_out,
    input  logic       borrow_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_carry,
    output logic       res_borrow,
    output logic       res_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [4:0] MAX_OP = 5'd19;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_t;

    state_t        state_q, state_d;
    logic [4:0]    memOp [DEPTH];
    logic [7:0]    memA  [DEPTH];
    logic [7:0]    memB  [DEPTH];
    logic [PW-1:0] wrPtr_q, rdPtr_q;
    logic [CW-1:0] count_q;
    logic [4:0]    opcode_q;
    logic [7:0]    operandA_q, operandB_q;
    logic [7:0]    resData_q;
    logic          resCarry_q, resBorrow_q, resErr_q;
    logic          carryFlag_q, borrowFlag_q;
    logic          push, pop, haveEntry, headIllegal;
    logic          startNext, loadIssue, capture, abortOp;

    assign haveEntry   = (count_q != '0);
    assign instr_ready = (count_q < CW'(DEPTH));
    assign push        = instr_valid && instr_ready;
    assign headIllegal = (memOp[rdPtr_q] > MAX_OP);

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q;
    logic          timerExpired;

    assign timerExpired = (timer_q == TW'(TIMEOUT - 1));

    // Watchdog: restart on the way into WAIT, count every cycle spent waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (state_q == ISSUE) begin
            timer_q <= '0;
        end else if (state_q == WAIT) begin
            timer_q <= timer_q + 1'b1;
        end
    end
`endif

    // Next-state logic: illegal heads bypass ISSUE and retire straight away as errors
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        startNext = 1'b0;
        loadIssue = 1'b0;
        capture   = 1'b0;
        abortOp   = 1'b0;
        case (state_q)
            IDLE: startNext = haveEntry;
            ISSUE: begin
                pop     = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (result_ready) begin
                    capture = 1'b1;
                    state_d = RETIRE;
                end
`ifdef ALU_ISSUE_TIMEOUT_EN
                else if (timerExpired) begin
                    abortOp = 1'b1;
                    state_d = RETIRE;
                end
`endif
            end
            RETIRE: begin
                if (res_ready) begin
                    state_d   = IDLE;
                    startNext = haveEntry;
                end
            end
            default: state_d = IDLE;
        endcase
        if (startNext) begin
            if (headIllegal) begin
                pop     = 1'b1;
                abortOp = 1'b1;
                state_d = RETIRE;
            end else begin
                loadIssue = 1'b1;
                state_d   = ISSUE;
            end
        end
    end

    // State register and FIFO bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are only meaningful below count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            memOp[wrPtr_q] <= instr_opcode;
            memA[wrPtr_q]  <= instr_a;
            memB[wrPtr_q]  <= instr_b;
        end
    end

    // ALU operand registers, loaded as an op enters ISSUE and held through WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q   <= '0;
            operandA_q <= '0;
            operandB_q <= '0;
        end else if (loadIssue) begin
            opcode_q   <= memOp[rdPtr_q];
            operandA_q <= memA[rdPtr_q];
            operandB_q <= memB[rdPtr_q];
        end
    end

    // Result register and carry chain; errors never disturb the chained flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resData_q    <= '0;
            resCarry_q   <= 1'b0;
            resBorrow_q  <= 1'b0;
            resErr_q     <= 1'b0;
            carryFlag_q  <= 1'b0;
            borrowFlag_q <= 1'b0;
        end else if (capture) begin
            resData_q    <= y_out;
            resCarry_q   <= carry_out;
            resBorrow_q  <= borrow_out;
            resErr_q     <= 1'b0;
            carryFlag_q  <= carry_out;
            borrowFlag_q <= borrow_out;
        end else if (abortOp) begin
            resData_q   <= '0;
            resCarry_q  <= 1'b0;
            resBorrow_q <= 1'b0;
            resErr_q    <= 1'b1;
        end
    end

    assign opcode      = opcode_q;
    assign operand_A   = operandA_q;
    assign operand_B   = operandB_q;
    assign enable      = (state_q == ISSUE) || (state_q == WAIT);
    assign input_ready = (state_q == ISSUE);
    assign carry_in    = carryFlag_q;
    assign borrow_in   = borrowFlag_q;
    assign res_valid   = (state_q == RETIRE);
    assign res_data    = resData_q;
    assign res_carry   = resCarry_q;
    assign res_borrow  = resBorrow_q;
    assign res_err     = resErr_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Testbench for alu_issue_queue: directed requests, a simple ALU responder and an
// in-order scoreboard that carries its own copy of the carry/borrow chain.
// Also builds with ALU_ISSUE_TIMEOUT_EN defined to exercise the watchdog.
module tb_alu_issue_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid, instr_ready;
    logic [4:0] instr_opcode;
    logic [7:0] instr_a, instr_b;
    logic [4:0] opcode;
    logic [7:0] operand_A, operand_B;
    logic       enable, input_ready, carry_in, borrow_in;
    logic       result_ready;
    logic [7:0] y_out;
    logic       carry_out, borrow_out;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_carry, res_borrow, res_err;

    typedef struct {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        bit         timedOut;
    } req_t;

    req_t reqQ[$];
    int   checks = 0;
    int   errors = 0;
    int   issueCount = 0;
    int   retireCount = 0;
    int   base;
    int   n;
    logic mCarry = 1'b0;
    logic mBorrow = 1'b0;
    bit   expectTimeout = 1'b0;
    bit   aluMute = 1'b0;
    int   aluDelay = 0;
    bit   aluPending = 1'b0;
    int   aluCnt = 0;
    logic [7:0] aluY, expY;
    logic aluC, aluB, expC, expB, expE;

    alu_issue_queue dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_a(instr_a), .instr_b(instr_b),
        .opcode(opcode), .operand_A(operand_A), .operand_B(operand_B),
        .enable(enable), .input_ready(input_ready),
        .carry_in(carry_in), .borrow_in(borrow_in),
        .result_ready(result_ready), .y_out(y_out),
        .carry_out(carry_out), .borrow_out(borrow_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_borrow(res_borrow), .res_err(res_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // What the ALU computes for a legal opcode
    function automatic void aluFn(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, input logic bin,
                                  output logic [7:0] y, output logic co, output logic bo);
        logic [8:0] t;
        co = 1'b0;
        bo = 1'b0;
        case (op)
            5'd0: begin t = {1'b0, a} + {1'b0, b}; y = t[7:0]; co = t[8]; end
            5'd1: begin t = {1'b0, a} + {1'b0, b} + {8'd0, cin}; y = t[7:0]; co = t[8]; end
            5'd2: begin t = {1'b0, a} - {1'b0, b}; y = t[7:0]; bo = t[8]; end
            5'd3: begin t = {1'b0, a} - {1'b0, b} - {8'd0, bin}; y = t[7:0]; bo = t[8]; end
            default: y = a ^ b;
        endcase
    endfunction

    function automatic logic [63:0] outVector();
        return {26'd0, opcode, operand_A, operand_B, enable, input_ready, carry_in, borrow_in,
                res_valid, res_data, res_carry, res_borrow, res_err, instr_ready};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event did not occur within its cycle budget", name);
    endtask

    // Offer one request and hold it until the DUT accepts it; returns just after the accepting edge
    task automatic applyStimulus(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        int waited = 0;
        req_t r;
        instr_valid  = 1'b1;
        instr_opcode = op;
        instr_a      = a;
        instr_b      = b;
        @(negedge clk);
        while (!instr_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) reportTimeout("pushAccept");
        @(posedge clk);
        #1;
        if (waited < 200) begin
            r.op = op; r.a = a; r.b = b; r.timedOut = expectTimeout;
            reqQ.push_back(r);
        end
        instr_valid = 1'b0;
    endtask

    task automatic waitResValid(input int budget);
        int k = 0;
        @(negedge clk);
        while (!res_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!res_valid) reportTimeout("resValid");
    endtask

    task automatic pulseResReady();
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    // ALU responder: latch operands in ISSUE, answer after aluDelay further cycles
    always @(negedge clk) begin
        result_ready = 1'b0;
        if (rst) begin
            aluPending = 1'b0;
        end else if (aluPending) begin
            if (aluCnt == 0) begin
                result_ready = 1'b1;
                y_out        = aluY;
                carry_out    = aluC;
                borrow_out   = aluB;
                aluPending   = 1'b0;
            end else begin
                aluCnt--;
            end
        end else if (input_ready && !aluMute) begin
            aluFn(opcode, operand_A, operand_B, carry_in, borrow_in, aluY, aluC, aluB);
            aluCnt     = aluDelay;
            aluPending = 1'b1;
        end
    end

    // Scoreboard: issued operands, chained flags at issue, and every retired result in order
    always @(negedge clk) begin
        if (!rst) begin
            if (enable) begin
                if (reqQ.size() == 0) begin
                    reportTimeout("issueWithoutRequest");
                end else begin
                    checkOutput("issueOperands", {opcode, operand_A, operand_B},
                                {reqQ[0].op, reqQ[0].a, reqQ[0].b});
                    if (input_ready) begin
                        issueCount++;
                        checkOutput("carryChain", {carry_in, borrow_in}, {mCarry, mBorrow});
                    end
                end
            end
            if (res_valid) begin
                if (reqQ.size() == 0) begin
                    reportTimeout("resultWithoutRequest");
                end else begin
                    if (reqQ[0].op > 5'd19 || reqQ[0].timedOut) begin
                        expY = 8'h00; expC = 1'b0; expB = 1'b0; expE = 1'b1;
                    end else begin
                        aluFn(reqQ[0].op, reqQ[0].a, reqQ[0].b, mCarry, mBorrow, expY, expC, expB);
                        expE = 1'b0;
                    end
                    checkOutput("retireResult", {res_data, res_carry, res_borrow, res_err},
                                {expY, expC, expB, expE});
                    if (res_ready) begin
                        void'(reqQ.pop_front());
                        retireCount++;
                        if (!expE) begin
                            mCarry  = expC;
                            mBorrow = expB;
                        end
                    end
                end
            end
        end
    end

    // Absolute time limit
    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] time limit");
    end

    // Directed sequence
    initial begin
        rst = 1'b1;
        instr_valid = 1'b0; instr_opcode = '0; instr_a = '0; instr_b = '0;
        result_ready = 1'b0; y_out = '0; carry_out = 1'b0; borrow_out = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetOutputs", outVector(), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idleAfterReset", outVector(), 64'd1);

        // ADD 0x05 + 0x03 with a slow ALU
        $display("[TB] ADD with delayed ALU");
        aluDelay = 2;
        base = issueCount;
        applyStimulus(5'd0, 8'h05, 8'h03);
        waitResValid(30);
        checkOutput("addData", {res_data, res_err}, {8'h08, 1'b0});
        checkOutput("addIssuePulses", issueCount - base, 1);
        pulseResReady();

        // ADD that carries, then an illegal op, then CADD must still see the carry
        $display("[TB] carry chain across an illegal opcode");
        aluDelay = 0;
        applyStimulus(5'd0, 8'hFF, 8'h01);
        waitResValid(30);
        checkOutput("addCarry", {res_data, res_carry}, {8'h00, 1'b1});
        pulseResReady();
        base = issueCount;
        applyStimulus(5'd25, 8'h12, 8'h34);
        waitResValid(30);
        checkOutput("illegalResult", {res_data, res_err}, {8'h00, 1'b1});
        checkOutput("illegalNoIssue", issueCount - base, 0);
        checkOutput("illegalKeepsCarry", carry_in, 1);
        pulseResReady();
        applyStimulus(5'd1, 8'h01, 8'h01);
        waitResValid(30);
        checkOutput("caddData", {res_data, res_err}, {8'h03, 1'b0});
        pulseResReady();

        // Fill the FIFO behind a held result, then drain with a refused push while full
        $display("[TB] FIFO full and in-order drain");
        base = retireCount;
        applyStimulus(5'd2, 8'h0A, 8'h14);
        waitResValid(30);
        checkOutput("subHeld", {res_data, res_borrow}, {8'hF6, 1'b1});
        @(posedge clk);
        #1;
        applyStimulus(5'd3, 8'h50, 8'h10);
        applyStimulus(5'd7, 8'hF0, 8'h0F);
        applyStimulus(5'd1, 8'h80, 8'h80);
        applyStimulus(5'd0, 8'h07, 8'h09);
        @(negedge clk);
        checkOutput("fullNotReady", instr_ready, 0);
        @(posedge clk);
        #1 res_ready = 1'b1;
        applyStimulus(5'd2, 8'h01, 8'h02);
        n = 0;
        while (reqQ.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (reqQ.size() > 0) reportTimeout("drain");
        @(posedge clk);
        #1 res_ready = 1'b0;
        checkOutput("drainCount", retireCount - base, 6);

`ifdef ALU_ISSUE_TIMEOUT_EN
        // Silent ALU: watchdog retires an error 15 cycles after entering WAIT
        $display("[TB] watchdog abort");
        aluMute = 1'b1;
        expectTimeout = 1'b1;
        applyStimulus(5'd0, 8'h01, 8'h01);
        expectTimeout = 1'b0;
        n = 0;
        @(negedge clk);
        while (!input_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!input_ready) reportTimeout("timeoutIssue");
        n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeoutLatency", n, 16);
        checkOutput("timeoutResult", {res_data, res_err}, {8'h00, 1'b1});
        pulseResReady();
`endif

        // Reset while waiting with two more requests queued
        $display("[TB] reset during WAIT");
        aluMute = 1'b1;
        applyStimulus(5'd0, 8'h02, 8'h02);
        applyStimulus(5'd7, 8'h01, 8'h01);
        applyStimulus(5'd5, 8'h01, 8'h01);
`ifdef ALU_ISSUE_TIMEOUT_EN
        repeat (2) @(negedge clk);
`else
        repeat (100) @(negedge clk);
`endif
        checkOutput("stillWaiting", {enable, input_ready, res_valid, instr_ready}, 4'b1001);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("asyncReset", outVector(), 64'd1);
        reqQ.delete();
        mCarry = 1'b0;
        mBorrow = 1'b0;
        aluMute = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        base = retireCount;
        repeat (20) @(negedge clk);
        checkOutput("quietAfterReset", {res_valid, enable, instr_ready}, 3'b001);
        checkOutput("noRetireAfterReset", retireCount - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Upstream issue stage for the 8-bit ALU. Buffers incoming operation requests in a small FIFO and presents them one at a time on the ALU's opcode/operand/input_ready interface. It holds the carry/borrow chain between operations and returns each ALU result, with its flags, over a valid/ready handshake. An optional watchdog aborts an operation that never completes.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- TIMEOUT, 15: maximum WAIT cycles before abort (only with the watchdog).
- clk  in  1  clock; all logic is clocked on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  request present.
- instr_ready  out  1  FIFO can accept a request; equals (count < DEPTH).
- instr_opcode  in  5  operation code; valid codes are 0..19.
- instr_a, instr_b  in  8  operands.
- opcode  out  5  to ALU.
- operand_A, operand_B  out  8  to ALU.
- enable  out  1  to ALU; high in ISSUE and WAIT.
- input_ready  out  1  to ALU; single-cycle pulse in ISSUE.
- carry_in, borrow_in  out  1  chained flags to ALU.
- result_ready  in  1  ALU result valid.
- y_out  in  8  ALU result.
- carry_out, borrow_out  in  1  ALU flags.
- res_valid  out  1  retired result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8  result value.
- res_carry, res_borrow  out  1  result flags.
- res_err  out  1  illegal opcode or timeout.

## Operation
- FIFO:
  - Push when instr_valid and instr_ready.
  - Pop on the ISSUE→WAIT transition, or on an illegal-opcode retire.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - No bypass: a request pushed in cycle N is visible to the FSM at N+1 at the earliest.
- FSM states and transitions:
  - IDLE: FIFO empty. Leave for ISSUE when count > 0.
  - ISSUE (1 cycle): drive the head entry on opcode/operand_A/operand_B, set input_ready=1 and enable=1, pop the FIFO, then go to WAIT.
  - Illegal opcode (>19) at the head: skip ISSUE. Go directly to RETIRE with res_data=0, res_err=1, carry/borrow=0, and do not touch the ALU.
  - WAIT: hold opcode and operands stable, input_ready=0, enable=1. On result_ready, capture y_out, carry_out and borrow_out into the result register, then go to RETIRE.
  - RETIRE: res_valid=1. When res_ready is high, go to ISSUE if count > 0, otherwise IDLE.
- Carry chain:
  - carry_flag and borrow_flag are registered. They update from the captured carry_out/borrow_out only on a non-error capture.
  - carry_in is driven from carry_flag and borrow_in from borrow_flag at all times.
  - Error retires leave both flags unchanged.
- Reset mid-operation: any in-flight op is dropped, the FIFO is emptied and the FSM returns to IDLE. No result is produced for the dropped op.

## Timing
- Reset values:
  - Outputs: instr_ready=1 and every other output 0.
  - Internal: state IDLE, count 0, carry_flag and borrow_flag 0.
- Latency: request accepted at cycle 0 gives ISSUE at cycle 1 and WAIT at cycle 2. res_valid rises the cycle after result_ready is sampled.
- Back-to-back: after a RETIRE handshake in cycle N, the next ISSUE occurs at N+1.
- Minimum throughput: one op per 4 cycles with an ALU that answers immediately.
- res_* outputs are stable while res_valid=1 and res_ready=0.
- result_ready is ignored outside WAIT.
- FIFO full: instr_ready=0. A push attempted in the same cycle as a pop while full is still refused.

## Configuration
- ALU_ISSUE_TIMEOUT_EN defined:
  - A 4-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without result_ready, go to RETIRE with res_err=1, res_data=0, and the flags unchanged.
  - A result_ready arriving in the same cycle as the timeout wins; no error is reported.
- Not defined: no counter is built and WAIT waits indefinitely.

## Test plan
- Reset, then push ADD(0) a=0x05 b=0x03; ALU model returns y_out=0x08 after 2 cycles → input_ready pulses once, and res_valid shows res_data=0x08, res_err=0.
- Push 5 requests with res_ready=0 and a DEPTH=4 FIFO, where the first has already issued → instr_ready drops after the 4 queued entries; release res_ready; all 5 retire in order.
- ADD with carry_out=1, then CADD(1) 0x01+0x01 → carry_in=1 while CADD is issued; the model returns 0x03.
- Push opcode 25 → no input_ready pulse; res_err=1, res_data=0x00; carry_flag unchanged.
- With ALU_ISSUE_TIMEOUT_EN and TIMEOUT=15, the ALU never responds → res_err=1 exactly 15 cycles after WAIT entry. Without the macro, the block is still in WAIT after 100 cycles.
- Assert rst in WAIT with 2 entries queued → all outputs go to their reset values immediately; no res_valid after release.
